// File: rtl/sign_mag_pkg.sv
// Shared definitions for the sign-magnitude sequential arithmetic blocks.
// Provides the controller state encoding, the serial-cell operation encoding,
// the default magnitude width and a helper that locates the sign bit.
package sign_mag_pkg;

    // Default magnitude width; operands are MAGW+1 bits with the sign on top.
    localparam int MAGW_DEFAULT = 4;

    // Controller states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        CALC = 2'd2,
        DONE = 2'd3
    } state_e;

    // Magnitude operation performed by the serial cell.
    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_e;

    // Bit index of the sign in a sign-magnitude word of the given magnitude width.
    function automatic int sign_idx(input int magw);
        return magw;
    endfunction

endpackage

// File: rtl/serial_addsub_bit.sv
// One-bit full adder / full subtractor used by the bit-serial datapath.
// Ports:
//   x    in  1  minuend / augend bit
//   y    in  1  subtrahend / addend bit
//   cin  in  1  incoming carry (add) or borrow (sub)
//   sub  in  1  1 = compute x - y - cin, 0 = compute x + y + cin
//   s    out 1  sum / difference bit
//   cout out 1  outgoing carry (add) or borrow (sub)
// Purely combinational; the carry/borrow flop lives in the parent.
module serial_addsub_bit (
    input  logic x,
    input  logic y,
    input  logic cin,
    input  logic sub,
    output logic s,
    output logic cout
);

    // Sum/difference and carry/borrow generation.
    always_comb begin
        s = x ^ y ^ cin;
        if (sub) begin
            // Borrow out when x < y + cin.
            cout = (~x & y) | (~(x ^ y) & cin);
        end else begin
            cout = (x & y) | (cin & (x ^ y));
        end
    end

endmodule

// File: rtl/sign_mag_sub_seq.sv
// Sequential sign-magnitude subtractor: diff = a - b, bit-serial LSB first.
// One operation takes MAGW+2 cycles from accept to result (CMP + MAGW x CALC).
// Ports:
//   clk       in  1       rising-edge clock
//   reset     in  1       synchronous active-high reset
//   in_valid  in  1       operands present
//   in_ready  out 1       block can accept operands (registered)
//   a         in  MAGW+1  minuend, sign in MSB (1 = negative)
//   b         in  MAGW+1  subtrahend, same format
//   out_valid out 1       result present (registered)
//   out_ready in  1       consumer accepts result
//   diff      out MAGW+1  sign-magnitude result, never -0
//   ovf       out 1       magnitude overflow (only possible on effective add)
module sign_mag_sub_seq
    import sign_mag_pkg::*;
#(
    parameter int MAGW = MAGW_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [MAGW:0]   a,
    input  logic [MAGW:0]   b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [MAGW:0]   diff,
    output logic            ovf
);

    localparam int SIGN = sign_idx(MAGW);
    localparam int CNTW = (MAGW > 1) ? $clog2(MAGW) : 1;
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(MAGW - 1);

    state_e          state_q, state_d;
    op_e             op_q, op_d;
    logic [MAGW:0]   a_q, a_d;
    logic [MAGW:0]   b_q, b_d;
    logic [MAGW-1:0] x_q, x_d;
    logic [MAGW-1:0] y_q, y_d;
    logic [MAGW-1:0] res_q, res_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic            carry_q, carry_d;
    logic            sign_q, sign_d;
    logic [MAGW:0]   diff_q, diff_d;
    logic            ovf_q, ovf_d;
    logic            out_valid_q, out_valid_d;
    logic            in_ready_q, in_ready_d;

    logic            op_sub_s;
    logic            bit_s;
    logic            bit_c;
    logic [MAGW-1:0] a_mag_s;
    logic [MAGW-1:0] b_mag_s;
    logic            a_neg_s;
    logic            sb_s;
    logic [MAGW:0]   res_cat_s;
    logic [MAGW-1:0] res_next_s;

    assign op_sub_s = (op_q == OP_SUB);

    serial_addsub_bit u_cell (
        .x    (x_q[0]),
        .y    (y_q[0]),
        .cin  (carry_q),
        .sub  (op_sub_s),
        .s    (bit_s),
        .cout (bit_c)
    );

    // Operand decode and result-shift helpers.
    always_comb begin
        a_mag_s    = a_q[MAGW-1:0];
        b_mag_s    = b_q[MAGW-1:0];
        // A -0 operand behaves as +0, so only a nonzero magnitude can be negative.
        a_neg_s    = a_q[SIGN] & (|a_mag_s);
        // Subtracting b is adding b with its effective sign inverted.
        sb_s       = ~(b_q[SIGN] & (|b_mag_s));
        // New bit enters at the top; after MAGW shifts bit 0 sits at the LSB.
        res_cat_s  = {bit_s, res_q};
        res_next_s = res_cat_s[MAGW:1];
    end

    // Next-state, datapath and output logic.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        x_d         = x_q;
        y_d         = y_q;
        res_d       = res_q;
        cnt_d       = cnt_q;
        carry_d     = carry_q;
        sign_d      = sign_q;
        diff_d      = diff_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;
        in_ready_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    a_d     = a;
                    b_d     = b;
                    state_d = CMP;
                end else begin
                    in_ready_d = 1'b1;
                end
            end

            CMP: begin
                if (a_neg_s == sb_s) begin
                    op_d   = OP_ADD;
                    sign_d = a_neg_s;
                    x_d    = a_mag_s;
                    y_d    = b_mag_s;
                end else begin
                    // Larger magnitude goes to the minuend so the borrow never escapes.
                    op_d = OP_SUB;
                    if (b_mag_s > a_mag_s) begin
                        x_d    = b_mag_s;
                        y_d    = a_mag_s;
                        sign_d = sb_s;
                    end else begin
                        x_d    = a_mag_s;
                        y_d    = b_mag_s;
                        sign_d = (a_mag_s == b_mag_s) ? 1'b0 : a_neg_s;
                    end
                end
                carry_d = 1'b0;
                cnt_d   = {CNTW{1'b0}};
                state_d = CALC;
            end

            CALC: begin
                x_d     = x_q >> 1;
                y_d     = y_q >> 1;
                res_d   = res_next_s;
                carry_d = bit_c;
                if (cnt_q == CNT_LAST) begin
                    // Zero magnitude always gets a positive sign.
                    diff_d      = {sign_q & (|res_next_s), res_next_s};
                    ovf_d       = (op_q == OP_ADD) & bit_c;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end else begin
                    cnt_d = cnt_q + CNTW'(1);
                end
            end

            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
                end else begin
                    out_valid_d = 1'b1;
                end
            end

            default: begin
                out_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            op_q        <= OP_ADD;
            a_q         <= {(MAGW+1){1'b0}};
            b_q         <= {(MAGW+1){1'b0}};
            x_q         <= {MAGW{1'b0}};
            y_q         <= {MAGW{1'b0}};
            res_q       <= {MAGW{1'b0}};
            cnt_q       <= {CNTW{1'b0}};
            carry_q     <= 1'b0;
            sign_q      <= 1'b0;
            diff_q      <= {(MAGW+1){1'b0}};
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            x_q         <= x_d;
            y_q         <= y_d;
            res_q       <= res_d;
            cnt_q       <= cnt_d;
            carry_q     <= carry_d;
            sign_q      <= sign_d;
            diff_q      <= diff_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign diff      = diff_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_sign_mag_sub_seq.sv
// Directed self-checking bench for sign_mag_sub_seq with MAGW=4.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_sign_mag_sub_seq;

    logic       clk;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [4:0] a;
    logic [4:0] b;
    logic       out_valid;
    logic       out_ready;
    logic [4:0] diff;
    logic       ovf;

    int n_assert;
    int n_fail;

    sign_mag_sub_seq #(.MAGW(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts and reports mismatches.
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Issue one operation from IDLE (called at a negedge) and check the result.
    task automatic run_op(input string tag, input logic [4:0] ta, input logic [4:0] tb_v,
                          input logic [4:0] ed, input logic eo, input bit release_now);
        int n;
        check_eq({tag, "_rdy_pre"}, in_ready, 1);
        a        = ta;
        b        = tb_v;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        check_eq({tag, "_busy"}, in_ready, 0);
        n = 0;
        while (!out_valid && n < 20) begin
            step();
            n++;
        end
        check_eq({tag, "_latency"}, n + 1, 6);
        check_eq({tag, "_diff"}, diff, ed);
        check_eq({tag, "_ovf"}, ovf, eo);
        if (release_now) begin
            out_ready = 1'b1;
            step();
            out_ready = 1'b0;
            check_eq({tag, "_rdy_post"}, in_ready, 1);
            check_eq({tag, "_vld_post"}, out_valid, 0);
        end
    endtask

    logic [4:0] pa [3];
    logic [4:0] pb [3];
    logic [4:0] pd [3];
    logic       po [3];

    initial begin
        n_assert  = 0;
        n_fail    = 0;
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = 5'b00000;
        b         = 5'b00000;

        // Reset and idle
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_diff", diff, 5'b00000);
        check_eq("rst_ovf", ovf, 0);
        check_eq("rst_in_ready", in_ready, 0);
        reset = 1'b0;
        step();
        check_eq("rel_in_ready", in_ready, 1);

        // Mixed sign, overflow, same sign, zero cases
        run_op("m6m2",   5'b10110, 5'b00010, 5'b11000, 1'b0, 1'b1);
        run_op("m11m3",  5'b11011, 5'b00011, 5'b11110, 1'b0, 1'b1);
        run_op("p8mm8",  5'b01000, 5'b11000, 5'b00000, 1'b1, 1'b1);
        run_op("p2m7",   5'b00010, 5'b00111, 5'b10101, 1'b0, 1'b1);
        run_op("p3m3",   5'b00011, 5'b00011, 5'b00000, 1'b0, 1'b1);
        run_op("p14mz",  5'b01110, 5'b10000, 5'b01110, 1'b0, 1'b1);

        // Backpressure: +5 - (-3) = +8 held in DONE
        run_op("bp", 5'b00101, 5'b10011, 5'b01000, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            check_eq("bp_vld", out_valid, 1);
            check_eq("bp_diff", diff, 5'b01000);
            check_eq("bp_ovf", ovf, 0);
            check_eq("bp_rdy", in_ready, 0);
            if (i == 2) begin
                a        = 5'b11111;
                b        = 5'b01111;
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check_eq("bp_rdy_after", in_ready, 1);
        check_eq("bp_idle_diff", diff, 5'b01000);
        repeat (3) step();
        check_eq("bp_no_capture", out_valid, 0);

        // Reset during the second CALC cycle
        a        = 5'b00111;
        b        = 5'b00001;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        step();
        reset = 1'b1;
        step();
        check_eq("mid_rst_vld", out_valid, 0);
        check_eq("mid_rst_rdy", in_ready, 0);
        check_eq("mid_rst_diff", diff, 5'b00000);
        reset = 1'b0;
        step();
        check_eq("mid_rel_rdy", in_ready, 1);
        check_eq("mid_rel_vld", out_valid, 0);
        run_op("after_rst", 5'b10101, 5'b01100, 5'b10001, 1'b1, 1'b1);

        // Back-to-back with in_valid and out_ready held high
        pa[0] = 5'b00101; pb[0] = 5'b00011; pd[0] = 5'b00010; po[0] = 1'b0;
        pa[1] = 5'b10001; pb[1] = 5'b10100; pd[1] = 5'b00011; po[1] = 1'b0;
        pa[2] = 5'b01111; pb[2] = 5'b11111; pd[2] = 5'b01110; po[2] = 1'b1;
        begin
            int  idx;
            int  k;
            int  cyc;
            int  last;
            bit  acc;
            idx       = 0;
            k         = 0;
            cyc       = 0;
            last      = 0;
            a         = pa[0];
            b         = pb[0];
            in_valid  = 1'b1;
            out_ready = 1'b1;
            while (k < 3 && cyc < 100) begin
                acc = in_valid & in_ready;
                step();
                cyc++;
                if (out_valid) begin
                    check_eq("b2b_diff", diff, pd[k]);
                    check_eq("b2b_ovf", ovf, po[k]);
                    if (k > 0) begin
                        check_eq("b2b_gap", cyc - last, 7);
                    end
                    last = cyc;
                    k++;
                end
                if (acc) begin
                    idx++;
                    if (idx < 3) begin
                        a = pa[idx];
                        b = pb[idx];
                    end else begin
                        in_valid = 1'b0;
                    end
                end
            end
            check_eq("b2b_count", k, 3);
            in_valid  = 1'b0;
            out_ready = 1'b0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
